inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter MEM_WORDS, default 1024, instruction-memory depth in 32-bit words (12-bit byte address space).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-low; asserted when reset=0 at a rising clk edge.
REQ-004 start  input  1  single-cycle pulse; begins a load, sampled only in IDLE or DONE.
REQ-005 word_count  input  11  number of words to load; sampled on the cycle start is accepted.
REQ-006 byte_valid  input  1  upstream byte source has byte_data valid.
REQ-007 byte_data  input  8  program byte, little-endian order within each word.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid and byte_ready are both 1.
REQ-009 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 mem_addr  output  12  instruction-memory byte address, word-aligned (bits [1:0]=0).
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 cpu_hold  output  1  1 holds the processor in reset; 0 releases it.
REQ-013 done  output  1  load completed successfully.
REQ-014 error  output  1  last start requested more words than MEM_WORDS.
REQ-015 checksum  output  8  XOR of every byte accepted since the last accepted start.

Function
REQ-016 FSM states: IDLE, RECV, WRITE, DONE.
REQ-017 IDLE: byte_ready=0, cpu_hold=1; start with word_count=0 -> DONE (done=1, no writes); start with word_count>MEM_WORDS -> DONE with error=1, no writes; other start -> RECV, word index=0, byte index=0, checksum=0.
REQ-018 RECV: byte_ready=1; each accepted byte is written to lane byte_index (byte 0 -> [7:0] ... byte 3 -> [31:24]), XORed into checksum, and byte_index increments mod 4.
REQ-019 Acceptance of the 4th byte of a word moves to WRITE on the next edge.
REQ-020 WRITE lasts exactly one cycle: mem_we=1, mem_addr={word_index,2'b00}, mem_wdata=assembled word, byte_ready=0.
REQ-021 WRITE exit: word_index=word_count-1 -> DONE; otherwise word_index increments and FSM returns to RECV.
REQ-022 Latency: mem_we asserts the cycle after the 4th byte is accepted; done asserts the cycle after the final WRITE.
REQ-023 DONE: cpu_hold=0, byte_ready=0; done=1 unless error=1; start re-arms exactly as from IDLE (reload), raising cpu_hold=1 on the following cycle.
REQ-024 start is ignored in RECV and WRITE; byte_valid is ignored whenever byte_ready=0.
REQ-025 mem_we=0 in every state other than WRITE; mem_addr and mem_wdata hold their last values outside WRITE.
REQ-026 word_index never exceeds MEM_WORDS-1; a word_count of exactly MEM_WORDS is legal and writes address 0xFFC last.
REQ-027 A byte stream stalled mid-word (byte_valid=0) holds all state indefinitely; no timeout.

Reset
REQ-028 On reset: state=IDLE, cpu_hold=1, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, checksum=0, and all indices=0.
REQ-029 Reset asserted mid-load abandons the load at that edge with no further write; a partially assembled word is discarded.

Structure
REQ-030 The state encoding localparams and the INST_MEM_BYTES=4096 constant belong in the shared package loader_pkg.
REQ-031 One sub-module, word_assembler (byte-lane register with byte_index counter and checksum XOR), is instantiated; the FSM and word counter remain in the top module.

Verification
REQ-032 Reset, then start with word_count=1, bytes 0x93,0x00,0x50,0x00 -> one mem_we with addr 0x000, data 0x00500093; done=1 and cpu_hold=0 the next cycle; checksum=0xC3.
REQ-033 word_count=3 with byte_valid toggling 1/0 each cycle -> writes to 0x000, 0x004, 0x008 only; byte_ready=0 during each WRITE.
REQ-034 start with word_count=0 -> DONE next cycle, done=1, no mem_we.
REQ-035 start with word_count=1025 -> error=1, done=0, no mem_we; start with word_count=1024 -> last write at addr 0xFFC, done=1.
REQ-036 reset driven to 0 after 2 bytes of word 1 -> IDLE next edge, cpu_hold=1, no mem_we; new load after release starts at addr 0x000.
REQ-037 start pulsed during RECV -> ignored; start in DONE -> cpu_hold=1 next cycle, reload begins at addr 0x000 with checksum cleared.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package loader_pkg;

  localparam int INST_MEM_BYTES = 4096;
  localparam int ADDR_W         = 12;
  localparam int CNT_W          = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RECV  = ST_RECV,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Byte-lane register: packs little-endian bytes into a 32-bit word and keeps a running XOR checksum.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_next,
  output logic        word_done,
  output logic [7:0]  checksum
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] lanes_q, lanes_d;
  logic [7:0]  chk_q, chk_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    lanes_d    = lanes_q;
    chk_d      = chk_q;
    word_done  = 1'b0;
    if (clear) begin
      byte_idx_d = 2'd0;
      lanes_d    = 32'd0;
      chk_d      = 8'd0;
    end else if (accept) begin
      lanes_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
      chk_d      = chk_q ^ byte_data;
      byte_idx_d = byte_idx_q + 2'd1;
      word_done  = (byte_idx_q == 2'd3);
    end
  end

  // word_next includes the byte arriving this cycle so the writer sees a complete word
  assign word_next = lanes_d;
  assign checksum  = chk_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_idx_q <= 2'd0;
      lanes_q    <= 32'd0;
      chk_q      <= 8'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
      chk_q      <= chk_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams program bytes into instruction memory word by word while holding the CPU in reset.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    word_count,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [7:0]          checksum
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MAX_WORDS = MEM_WORDS;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic               byte_ready_q, byte_ready_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               accept;
  logic               clear;
  logic               word_done;
  logic [31:0]        word_next;
  logic               last_word;

  assign accept    = byte_valid && byte_ready_q;
  assign clear     = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_word = (CNT_W'(word_idx_q) == (word_count_q - CNT_W'(1)));

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .accept    (accept),
    .byte_data (byte_data),
    .word_next (word_next),
    .word_done (word_done),
    .checksum  (checksum)
  );

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    word_count_d = word_count_q;
    byte_ready_d = byte_ready_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    error_d      = error_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          word_idx_d   = '0;
          word_count_d = word_count;
          done_d       = 1'b0;
          error_d      = 1'b0;
          if (word_count == '0) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else if ({{(32-CNT_W){1'b0}}, word_count} > MAX_WORDS) begin
            state_d    = DONE;
            error_d    = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d      = RECV;
            byte_ready_d = 1'b1;
            cpu_hold_d   = 1'b1;
          end
        end
      end
      RECV: begin
        if (word_done) begin
          state_d      = WRITE;
          byte_ready_d = 1'b0;
          mem_we_d     = 1'b1;
          mem_addr_d   = ADDR_W'({word_idx_q, 2'b00});
          mem_wdata_d  = word_next;
        end
      end
      WRITE: begin
        if (last_word) begin
          state_d    = DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else begin
          state_d      = RECV;
          word_idx_d   = word_idx_q + 1'b1;
          byte_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      word_count_q <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      word_count_q <= word_count_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected writes are queued, a negedge monitor checks them.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [7:0]  checksum;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  inst_mem_loader #(.MEM_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {20'd0, mem_addr}, {20'd0, e.addr});
        check("wr_data", mem_wdata, e.data);
        check("ready_in_write", {31'd0, byte_ready}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [10:0] cnt);
    start      = 1'b1;
    word_count = cnt;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok         = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (byte_ready) ok = 1'b1;
      tick();
    end
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    logic [31:0] tmp;
    tmp = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(tmp[8*k +: 8]);
      if (toggle) begin
        byte_valid = 1'b0;
        tick();
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (done) ok = 1'b1;
      else tick();
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic push(input logic [11:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words3 [3];
    logic [31:0] w;
    logic [7:0]  chk_model;

    reset = 1'b0; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) tick();
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_checksum", {24'd0, checksum}, 32'd0);
    reset = 1'b1;
    tick();

    // Single word: latency of write strobe and done
    push(12'h000, 32'h0050_0093);
    pulse_start(11'd1);
    check("recv_ready", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    byte_valid = 1'b0;
    check("t1_we_latency", {31'd0, mem_we}, 32'd1);
    check("t1_hold_during", {31'd0, cpu_hold}, 32'd1);
    tick();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("t1_checksum", {24'd0, checksum}, 32'h0000_00C3);
    check("t1_we_off", {31'd0, mem_we}, 32'd0);

    // Three words with byte_valid toggling
    words3[0] = 32'h1122_3344; words3[1] = 32'hDEAD_BEEF; words3[2] = 32'h0000_FFFF;
    push(12'h000, words3[0]); push(12'h004, words3[1]); push(12'h008, words3[2]);
    pulse_start(11'd3);
    check("t2_hold", {31'd0, cpu_hold}, 32'd1);
    for (int j = 0; j < 3; j++) send_word(words3[j], 1'b1);
    wait_done("t2_done");
    check("t2_checksum", {24'd0, checksum}, 32'h0000_0066);
    check("t2_addr_hold", {20'd0, mem_addr}, 32'h0000_0008);
    check("t2_data_hold", mem_wdata, 32'h0000_FFFF);

    // Zero-length load from DONE
    pulse_start(11'd0);
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_error", {31'd0, error}, 32'd0);
    check("t3_checksum_clr", {24'd0, checksum}, 32'd0);
    repeat (3) tick();

    // Oversize request
    pulse_start(11'd1025);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_done", {31'd0, done}, 32'd0);
    check("t4_ready", {31'd0, byte_ready}, 32'd0);
    repeat (3) tick();

    // Full-depth load
    chk_model = 8'd0;
    pulse_start(11'd1024);
    check("t5_error_clr", {31'd0, error}, 32'd0);
    for (int i = 0; i < 1024; i++) begin
      w = {i[7:0] ^ 8'h5A, 8'h3C, i[15:8], i[7:0]};
      chk_model = chk_model ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      push(12'(i * 4), w);
      send_word(w, 1'b0);
    end
    wait_done("t5_done");
    check("t5_last_addr", {20'd0, mem_addr}, 32'h0000_0FFC);
    check("t5_checksum", {24'd0, checksum}, {24'd0, chk_model});

    // Start during RECV is ignored; start in DONE reloads
    push(12'h000, 32'h0403_0201);
    pulse_start(11'd1);
    send_byte(8'h01); send_byte(8'h02);
    byte_valid = 1'b0;
    pulse_start(11'd5);
    check("t6_ignored_start_ready", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h03); send_byte(8'h04);
    byte_valid = 1'b0;
    wait_done("t6_done");
    check("t6_checksum", {24'd0, checksum}, 32'h0000_0004);
    push(12'h000, 32'hA0B0_C0D0);
    pulse_start(11'd1);
    check("t6_rearm_hold", {31'd0, cpu_hold}, 32'd1);
    check("t6_rearm_done", {31'd0, done}, 32'd0);
    check("t6_rearm_chk", {24'd0, checksum}, 32'd0);
    send_word(32'hA0B0_C0D0, 1'b0);
    wait_done("t6_reload_done");

    // Reset mid-load discards the partial word
    push(12'h000, 32'h1234_5678);
    pulse_start(11'd2);
    send_word(32'h1234_5678, 1'b0);
    send_byte(8'hEE); send_byte(8'hFF);
    byte_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("t7_rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("t7_rst_ready", {31'd0, byte_ready}, 32'd0);
    check("t7_rst_we", {31'd0, mem_we}, 32'd0);
    check("t7_rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    tick();
    push(12'h000, 32'hCAFE_F00D);
    pulse_start(11'd1);
    send_word(32'hCAFE_F00D, 1'b0);
    wait_done("t7_done");
    check("t7_checksum", {24'd0, checksum}, 32'h0000_00C9);

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
